array_ctrl: RTL
===============

ARRAY_CTRL -- requirements
Module: array_ctrl

Interface
REQ-001 Parameter HEIGHT, default 8, array rows.
REQ-002 Parameter WIDTH, default 8, array columns.
REQ-003 Parameter VWIDTH, default 8, width of vector-count field.
REQ-004 Parameter LWIDTH, default 15, width of MAC-length field (IWIDTH-1).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  tile request, sampled in IDLE only.
REQ-008 abort  in  1  synchronous abort.
REQ-009 num_vec  in  VWIDTH  input vectors per tile, latched at start; 0 means 2^VWIDTH.
REQ-010 mac_len  in  LWIDTH  cycles per unary temporal MAC, latched at start; 0 means 1.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 wght_rd / ifm_rd  out  1 each  weight-fetch and ifm-fetch strobes.
REQ-014 en_w, clr_w  out  WIDTH each  column weight controls.
REQ-015 en_i, clr_i, mac_done  out  HEIGHT each  row input controls.
REQ-016 en_o, clr_o  out  WIDTH each  column output-drain controls.
REQ-017 ofm_vld  out  1  array ofm bus valid.
REQ-018 perf_cyc  out  32  busy-cycle count.

Function
REQ-019 FSM states IDLE, WLOAD, MAC, DRAIN, DONE; one-hot or binary at implementer's choice.
REQ-020 IDLE->WLOAD when start=1 and abort=0; num_vec, mac_len latched on the same edge.
REQ-021 WLOAD lasts HEIGHT cycles: en_w all ones and wght_rd=1 every cycle; clr_w all ones on the first cycle only.
REQ-022 MAC lasts N*L+HEIGHT-1 cycles (N, L = effective num_vec, mac_len).
REQ-023 Base row strobes during the first N*L MAC cycles: en=1 throughout; clr=1 on the first cycle of each vector; mac_done=1 on the last cycle of each vector; all 0 in the final HEIGHT-1 cycles.
REQ-024 Row h en_i/clr_i/mac_done = base strobes delayed by exactly h cycles (row 0 undelayed).
REQ-025 ifm_rd = base clr (row-0 timing).
REQ-026 L=1: clr and mac_done both high on every vector cycle.
REQ-027 DRAIN lasts HEIGHT cycles: en_o all ones and ofm_vld=1; clr_o all ones on the last DRAIN cycle only.
REQ-028 DONE lasts one cycle with done=1, then IDLE.
REQ-029 start outside IDLE is ignored, with no queuing.
REQ-030 abort=1 in any state -> IDLE next cycle; skew registers cleared; no done pulse; abort has priority over simultaneous start.
REQ-031 Vector and cycle counters are internal; sized to hold 2^VWIDTH and 2^LWIDTH without wrap.
REQ-032 All outputs registered; no combinational input-to-output path.

Reset
REQ-033 rst_n=0 forces IDLE and clears all counters, skew registers and perf_cyc.
REQ-034 Every output is 0 during and immediately after reset.
REQ-035 Reset mid-tile discards the tile; no done pulse is issued.

Configuration
REQ-036 With ARRAY_CTRL_PERF_EN defined: perf_cyc increments each cycle busy=1, saturates at 2^32-1, and clears on start acceptance.
REQ-037 Without ARRAY_CTRL_PERF_EN: perf_cyc is constant 0 and no counter logic exists.

Structure
REQ-038 Package array_ctrl_pkg holds the state enum, default HEIGHT/WIDTH/VWIDTH/LWIDTH constants, and a 3-bit row-strobe struct {en, clr, mac_done}.
REQ-039 Sub-module skew_line (parameter DEPTH) delays the row-strobe struct by DEPTH cycles with async-reset flops; one instance per row h>0.

Verification
REQ-040 Start at cycle 0, N=1, L=4 -> busy cycles 1-28; WLOAD 1-8; row0 en_i 9-12; row7 en_i 16-19; DRAIN 20-27; done at 28 only.
REQ-041 N=3, L=2 -> row0 clr_i at cycles 9, 11, 13; row0 mac_done at 10, 12, 14; ifm_rd matches row0 clr_i; row3 strobes shifted +3.
REQ-042 mac_len=0, N=2 -> treated as L=1; row0 clr_i=mac_done=1 at cycles 9-10; MAC state lasts 9 cycles.
REQ-043 Abort at cycle 12 of the REQ-040 run -> all outputs 0 from cycle 13; no done; a new start at cycle 14 produces a full, correct run.
REQ-044 Start re-asserted during MAC -> no effect; rst_n low at cycle 10 -> all outputs 0 asynchronously.
REQ-045 PERF_EN defined, REQ-040 run -> perf_cyc=28 after done; undefined -> perf_cyc=0 throughout.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// Shared types and default geometry for the systolic-array tile controller.
// Holds the controller state encoding and the 3-bit per-row strobe bundle
// that is skewed down the array rows.
package array_ctrl_pkg;

    localparam int DEF_HEIGHT = 8;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_VWIDTH = 8;
    localparam int DEF_LWIDTH = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic en;
        logic clr;
        logic mac_done;
    } row_strb_t;

endpackage

// File: rtl/array_ctrl_skew_line.sv
// Fixed delay line for one array row's strobe bundle (DEPTH cycles).
// Ports: clk, rst_n (async active-low), flush (sync clear of every stage),
//        din (row-0 strobes), dout (strobes delayed by DEPTH cycles).
module skew_line
    import array_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  row_strb_t din,
    output row_strb_t dout
);

    row_strb_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/array_ctrl.sv
// Tile sequencer for a HEIGHT x WIDTH unary temporal MAC array:
// weight load, skewed row MAC strobes, output drain, done pulse.
// Ports: start/abort/num_vec/mac_len in; busy, done, fetch strobes, per-column
//        and per-row array controls, ofm_vld, perf_cyc out. All outputs are flops.
// Optional busy-cycle counter is built only when ARRAY_CTRL_PERF_EN is defined.
module array_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int VWIDTH = DEF_VWIDTH,
    parameter int LWIDTH = DEF_LWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [VWIDTH-1:0] num_vec,
    input  logic [LWIDTH-1:0] mac_len,
    output logic              busy,
    output logic              done,
    output logic              wght_rd,
    output logic              ifm_rd,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [HEIGHT-1:0] mac_done,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o,
    output logic              ofm_vld,
    output logic [31:0]       perf_cyc
);

    localparam int CW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0]   H_LAST = CW'(HEIGHT - 1);
    // Last count of the HEIGHT-1 cycle skew tail at the end of MAC.
    localparam logic [CW-1:0]   T_LAST = CW'((HEIGHT > 1) ? HEIGHT - 2 : 0);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);
    localparam logic [VWIDTH:0] N_ONE  = 1;
    localparam logic [LWIDTH:0] L_ONE  = 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VWIDTH:0] vcnt_q, vcnt_d, n_q, n_last;
    logic [LWIDTH:0] lcnt_q, lcnt_d, l_q, l_last;
    logic            tail_q, tail_d;
    logic            accept;
    row_strb_t       base_d, base_q;
    logic            busy_q, done_q, wload_q, clrw_q, drain_q, clro_q;

    // One extra bit so that 0 can encode 2^VWIDTH vectors; mac_len 0 means 1.
    assign n_last = n_q - N_ONE;
    assign l_last = l_q - L_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vcnt_d  = vcnt_q;
        lcnt_d  = lcnt_q;
        tail_d  = tail_q;
        accept  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            vcnt_d  = '0;
            lcnt_d  = '0;
            tail_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        accept  = 1'b1;
                        state_d = S_WLOAD;
                        cnt_d   = '0;
                    end
                end
                S_WLOAD: begin
                    if (cnt_q == H_LAST) begin
                        state_d = S_MAC;
                        cnt_d   = '0;
                        vcnt_d  = '0;
                        lcnt_d  = '0;
                        tail_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                S_MAC: begin
                    if (!tail_q) begin
                        if (lcnt_q == l_last) begin
                            lcnt_d = '0;
                            if (vcnt_q == n_last) begin
                                vcnt_d = '0;
                                // A single-row array has no skew tail.
                                tail_d = (HEIGHT > 1);
                                if (HEIGHT == 1) state_d = S_DRAIN;
                            end else begin
                                vcnt_d = vcnt_q + N_ONE;
                            end
                        end else begin
                            lcnt_d = lcnt_q + L_ONE;
                        end
                    end else if (cnt_q == T_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                        tail_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == H_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from next-state values and then registered,
        // so every output flop reflects the state it is presented in.
        base_d.en       = (state_d == S_MAC) && !tail_d;
        base_d.clr      = base_d.en && (lcnt_d == '0);
        base_d.mac_done = base_d.en && (lcnt_d == l_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vcnt_q  <= '0;
            lcnt_q  <= '0;
            tail_q  <= 1'b0;
            n_q     <= '0;
            l_q     <= '0;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wload_q <= 1'b0;
            clrw_q  <= 1'b0;
            drain_q <= 1'b0;
            clro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vcnt_q  <= vcnt_d;
            lcnt_q  <= lcnt_d;
            tail_q  <= tail_d;
            if (accept) begin
                n_q <= (num_vec == '0) ? {1'b1, {VWIDTH{1'b0}}} : {1'b0, num_vec};
                l_q <= (mac_len == '0) ? L_ONE : {1'b0, mac_len};
            end
            base_q  <= base_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            wload_q <= (state_d == S_WLOAD);
            clrw_q  <= (state_d == S_WLOAD) && (cnt_d == '0);
            drain_q <= (state_d == S_DRAIN);
            clro_q  <= (state_d == S_DRAIN) && (cnt_d == H_LAST);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wght_rd = wload_q;
    assign en_w    = {WIDTH{wload_q}};
    assign clr_w   = {WIDTH{clrw_q}};
    assign en_o    = {WIDTH{drain_q}};
    assign clr_o   = {WIDTH{clro_q}};
    assign ofm_vld = drain_q;
    assign ifm_rd  = base_q.clr;

    // Row h sees the row-0 strobes h cycles later; abort flushes the skew.
    row_strb_t row [HEIGHT];

    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        if (h == 0) begin : g_base
            assign row[h] = base_q;
        end else begin : g_skew
            skew_line #(.DEPTH(h)) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (abort),
                .din   (base_q),
                .dout  (row[h])
            );
        end
        assign en_i[h]     = row[h].en;
        assign clr_i[h]    = row[h].clr;
        assign mac_done[h] = row[h].mac_done;
    end

`ifdef ARRAY_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cyc = perf_q;
`else
    assign perf_cyc = '0;
`endif

endmodule
